// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mul_state_t;

  localparam int unsigned DEFAULT_SIZE = 16;
  localparam int unsigned CNT_W        = $clog2(DEFAULT_SIZE + 1);

  // Counter width for an arbitrary operand size (must hold the value SIZE).
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational conditional two's-complement negation.
module cond_negate #(
  parameter int unsigned W = 16
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/seq_signed_multiplier.sv
// Multi-cycle signed/unsigned shift-add multiplier, SIZE+2 cycles per operation.
// Optional overflow flag on the ovf port when MUL_OVF_EN is defined.
module seq_signed_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
`ifdef MUL_OVF_EN
  output logic              ovf,
`endif
  output logic [2*SIZE-1:0] product
);

  localparam int unsigned CntW = cnt_width(SIZE);

  mul_state_t state_q, state_d;

  logic [SIZE-1:0]   mcand_q, mcand_d;
  logic [SIZE-1:0]   acc_q, acc_d;
  logic [SIZE-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [2*SIZE-1:0] product_q, product_d;

  logic [SIZE-1:0]   a_mag, b_mag;
  logic [SIZE:0]     sum;
  logic [2*SIZE-1:0] res_fix;

  cond_negate #(.W(SIZE)) u_neg_a (
    .neg_i (signed_mode & a[SIZE-1]),
    .in_i  (a),
    .out_o (a_mag)
  );

  cond_negate #(.W(SIZE)) u_neg_b (
    .neg_i (signed_mode & b[SIZE-1]),
    .in_i  (b),
    .out_o (b_mag)
  );

  cond_negate #(.W(2*SIZE)) u_neg_res (
    .neg_i (neg_q),
    .in_i  ({acc_q, mplier_q}),
    .out_o (res_fix)
  );

  // Carry is kept in sum[SIZE] and shifted into the accumulator MSB.
  assign sum = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};

`ifdef MUL_OVF_EN
  logic              sgn_q, sgn_d;
  logic              ovf_q, ovf_d;
  logic [SIZE:0]     res_hi_s;
  logic              ovf_calc;

  assign res_hi_s = res_fix[2*SIZE-1:SIZE-1];
  assign ovf_calc = sgn_q ? !((res_hi_s == '0) || (res_hi_s == '1))
                          : (res_fix[2*SIZE-1:SIZE] != '0);
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    product_d = product_q;
`ifdef MUL_OVF_EN
    sgn_d     = sgn_q;
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CntW'(SIZE);
          neg_d    = signed_mode & (a[SIZE-1] ^ b[SIZE-1]);
`ifdef MUL_OVF_EN
          sgn_d    = signed_mode;
`endif
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = sum[SIZE:1];
        mplier_d = {sum[0], mplier_q[SIZE-1:1]};
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = FIX;
      end
      FIX: begin
        product_d = res_fix;
        done_d    = 1'b1;
`ifdef MUL_OVF_EN
        ovf_d     = ovf_calc;
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MUL_OVF_EN
      sgn_q     <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      product_q <= product_d;
`ifdef MUL_OVF_EN
      sgn_q     <= sgn_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;
`ifdef MUL_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed self-checking bench for seq_signed_multiplier at SIZE=16.
module tb_seq_signed_multiplier;

  localparam int unsigned SIZE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
`ifdef MUL_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  seq_signed_multiplier #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
`ifdef MUL_OVF_EN
    .ovf         (ovf),
`endif
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves us at the negedge one cycle after the start edge.
  task automatic start_op(input logic sm, input logic [15:0] av, input logic [15:0] bv);
    start       = 1'b1;
    signed_mode = sm;
    a           = av;
    b           = bv;
    @(negedge clk);
    start       = 1'b0;
    a           = 16'hxxxx;
    b           = 16'hxxxx;
  endtask

  // Cycle 1 is the current negedge; returns at the negedge of the done cycle.
  task automatic wait_done(input bit noise, output int lat, output int bc);
    int cyc;
    cyc = 1;
    lat = -1;
    bc  = 0;
    while (cyc <= 40) begin
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) bc++;
      if (noise && cyc >= 3 && cyc <= 6) begin
        start       = 1'b1;
        signed_mode = 1'b1;
        a           = 16'h1234 + 16'(cyc);
        b           = 16'h8765;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic sm, input logic [15:0] av,
                     input logic [15:0] bv, input logic [31:0] exp_p, input logic exp_o);
    int lat;
    int bc;
    start_op(sm, av, bv);
    wait_done(1'b0, lat, bc);
    chk({tag, "_lat"}, lat, 32'd18);
    chk({tag, "_busycnt"}, bc, 32'd17);
    chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_prod"}, product, exp_p);
`ifdef MUL_OVF_EN
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_o});
`else
    if (exp_o === 1'bx) $display("unreachable");
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    int dcnt;

    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_prod", product, 32'd0);
`ifdef MUL_OVF_EN
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run("u_ffff",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
    run("s_m3x5",   1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 1'b0);
    run("s_0xm7",   1'b1, 16'h0000, 16'hFFF9, 32'h0000_0000, 1'b0);
    run("s_minmin", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
    run("s_minx1",  1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000, 1'b0);
    run("u_8000x2", 1'b0, 16'h8000, 16'h0002, 32'h0001_0000, 1'b1);
    run("u_ffx100", 1'b0, 16'h00FF, 16'h0100, 32'h0000_FF00, 1'b0);
    run("s_maxmax", 1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b1);
    run("s_m1xm1",  1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
    run("s_256xm256", 1'b1, 16'h0100, 16'hFF00, 32'hFFFF_0000, 1'b1);

    // Start pulses while busy must be ignored.
    start_op(1'b0, 16'd3, 16'd5);
    wait_done(1'b1, lat, bc);
    chk("ign_lat", lat, 32'd18);
    chk("ign_prod", product, 32'd15);
    // Start in the done cycle is accepted; old product holds meanwhile.
    start_op(1'b0, 16'd2, 16'd3);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_hold", product, 32'd15);
    wait_done(1'b0, lat, bc);
    chk("b2b_lat", lat, 32'd18);
    chk("b2b_prod", product, 32'd6);
    @(negedge clk);

    // Reset in the middle of CALC aborts without a done pulse.
    start_op(1'b0, 16'd100, 16'd200);
    repeat (8) @(negedge clk);
    chk("mid_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_prod", product, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mid_no_done", dcnt, 32'd0);
    run("post_rst", 1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
